// File: rtl/config_shift_chain_bank.sv
// rtl/config_shift_chain_bank.sv - bank of serially loaded shadow/active configuration chains
module config_shift_chain_bank #(
    parameter int NUM_CHAINS = 4,
    parameter int CHAIN_LEN  = 64,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 2)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cen,
    input  logic [NUM_CHAINS-1:0]            shift_in,
    input  logic [NUM_CHAINS-1:0]            set_in,
    input  logic                             err_clr,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0]  config_out,
    output logic [NUM_CHAINS-1:0]            scan_out,
    output logic [NUM_CHAINS-1:0]            config_valid,
    output logic [NUM_CHAINS-1:0]            len_err,
    output logic [NUM_CHAINS*CNT_W-1:0]      bit_count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(CHAIN_LEN + 1);

    for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chain
        logic [CHAIN_LEN-1:0] shadow;
        logic [CHAIN_LEN-1:0] active;
        logic [CNT_W-1:0]     cnt;
        logic                 valid;
        logic                 err;
        logic                 do_set;
        logic                 do_shift;
        logic                 set_err;

        assign do_set   = cen & set_in[i];
        assign do_shift = cen & ~set_in[i];
        assign set_err  = do_set & (cnt != FULL_CNT);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow <= '0;
                active <= '0;
                cnt    <= '0;
                valid  <= 1'b0;
                err    <= 1'b0;
            end else begin
                if (do_set) begin
                    active <= shadow;
                    valid  <= (cnt == FULL_CNT);
                    cnt    <= '0;
                end else if (do_shift) begin
                    shadow <= {shadow[CHAIN_LEN-2:0], shift_in[i]};
                    // Saturate one past full so overruns stay distinguishable from exact loads
                    if (cnt != OVER_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // An erroring set overrides a simultaneous clear
                if (set_err) begin
                    err <= 1'b1;
                end else if (cen && err_clr) begin
                    err <= 1'b0;
                end
            end
        end

        assign config_out[i*CHAIN_LEN +: CHAIN_LEN] = active;
        assign bit_count[i*CNT_W +: CNT_W]          = cnt;
        assign scan_out[i]                          = shadow[CHAIN_LEN-1];
        assign config_valid[i]                      = valid;
        assign len_err[i]                           = err;
    end

endmodule

// File: tb/tb_config_shift_chain_bank.sv
// tb/tb_config_shift_chain_bank.sv - directed self-checking bench for config_shift_chain_bank
module tb_config_shift_chain_bank;

    localparam int NC = 4;
    localparam int CL = 8;
    localparam int CW = 4;

    logic             clk;
    logic             rst_n;
    logic             cen;
    logic [NC-1:0]    shift_in;
    logic [NC-1:0]    set_in;
    logic             err_clr;
    logic [NC*CL-1:0] config_out;
    logic [NC-1:0]    scan_out;
    logic [NC-1:0]    config_valid;
    logic [NC-1:0]    len_err;
    logic [NC*CW-1:0] bit_count;

    int errors = 0;
    int checks = 0;

    config_shift_chain_bank #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cen          (cen),
        .shift_in     (shift_in),
        .set_in       (set_in),
        .err_clr      (err_clr),
        .config_out   (config_out),
        .scan_out     (scan_out),
        .config_valid (config_valid),
        .len_err      (len_err),
        .bit_count    (bit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [NC-1:0] sh, input logic [NC-1:0] st,
                         input logic clr);
        cen      = c;
        shift_in = sh;
        set_in   = st;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] cfg, input logic [15:0] cnt,
                           input logic [3:0] vld, input logic [3:0] err);
        chk({tag, ".config_out"}, config_out, cfg);
        chk({tag, ".bit_count"}, 32'(bit_count), 32'(cnt));
        chk({tag, ".config_valid"}, 32'(config_valid), 32'(vld));
        chk({tag, ".len_err"}, 32'(len_err), 32'(err));
    endtask

    initial begin
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  d3;
        logic [11:0] d12;

        rst_n    = 1'b1;
        cen      = 1'b0;
        shift_in = '0;
        set_in   = '0;
        err_clr  = 1'b0;
        #3 rst_n = 1'b0;

        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        chk_all("reset", 32'h0, 16'h0, 4'h0, 4'h0);
        chk("reset.scan_out", 32'(scan_out), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        end
        chk_all("idle", 32'h0, 16'h0, 4'h0, 4'h0);
        chk("idle.scan_out", 32'(scan_out), 32'h0);

        // Exact load: chain0 = AA, chain3 = F0, MSB first
        d0 = 8'hAA;
        d3 = 8'hF0;
        for (int k = 7; k >= 0; k--) begin
            drive(1'b1, {d3[k], 1'b0, 1'b0, d0[k]}, 4'b0000, 1'b0);
        end
        chk("exact.pre_scan", 32'(scan_out), 32'h9);
        chk("exact.pre_cfg", config_out, 32'h0);
        chk("exact.pre_cnt", 32'(bit_count), 32'h8888);
        drive(1'b1, 4'b0000, 4'b1001, 1'b0);
        chk_all("exact", 32'hF00000AA, 16'h0990, 4'b1001, 4'b0000);
        chk("exact.scan_kept", 32'(scan_out), 32'h9);

        // Set on chain1 with err_clr in the same cycle: set wins
        drive(1'b1, 4'b0000, 4'b0010, 1'b1);
        chk("setwins.len_err", 32'(len_err), 32'b0010);
        chk("setwins.cfg", config_out, 32'hF00000AA);

        // Short load of 5 bits into chain1; first shift also clears errors
        d1 = 8'h16;
        drive(1'b1, {2'b00, d1[4], 1'b0}, 4'b0000, 1'b1);
        chk("clr.len_err", 32'(len_err), 32'h0);
        for (int k = 3; k >= 0; k--) begin
            drive(1'b1, {2'b00, d1[k], 1'b0}, 4'b0000, 1'b0);
        end
        chk("short.pre_cnt", 32'(bit_count), 32'h6956);
        drive(1'b1, 4'b0000, 4'b0010, 1'b0);
        chk_all("short", 32'hF00016AA, 16'h7907, 4'b1001, 4'b0010);

        // err_clr alongside an erroring set on chain2: chain1 clears, chain2 raised
        drive(1'b1, 4'b0000, 4'b0100, 1'b1);
        chk("clrmix.len_err", 32'(len_err), 32'b0100);

        // Overrun: 12 bits into chain2
        d12 = 12'hA5C;
        drive(1'b1, {1'b0, d12[11], 2'b00}, 4'b0000, 1'b1);
        chk("over.clr", 32'(len_err), 32'h0);
        for (int k = 10; k >= 0; k--) begin
            drive(1'b1, {1'b0, d12[k], 2'b00}, 4'b0000, 1'b0);
        end
        chk("over.sat_cnt", 32'(bit_count), 32'h9999);
        drive(1'b1, 4'b0000, 4'b0100, 1'b0);
        chk_all("over", 32'hF05C16AA, 16'h9099, 4'b1001, 4'b0100);

        // cen low: everything ignored
        drive(1'b0, 4'b1111, 4'b1111, 1'b1);
        drive(1'b0, 4'b1111, 4'b1111, 1'b1);
        chk_all("gate", 32'hF05C16AA, 16'h9099, 4'b1001, 4'b0100);

        // Set with shift_in high: shadow0 must stay 00, proven by an immediate re-latch
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        drive(1'b1, 4'b0000, 4'b0001, 1'b0);
        chk_all("setshift", 32'hF05C1600, 16'h9290, 4'b1000, 4'b0101);

        // Reset mid-load
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'b0001, 4'b0000, 1'b0);
        end
        chk("midload.cnt", 32'(bit_count), 32'h9694);
        rst_n = 1'b0;
        #2;
        chk_all("midreset", 32'h0, 16'h0, 4'h0, 4'h0);
        chk("midreset.scan_out", 32'(scan_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = 8'h3C;
        for (int k = 7; k >= 0; k--) begin
            drive(1'b1, {3'b000, d0[k]}, 4'b0000, 1'b0);
        end
        chk("reload.pre_cnt", 32'(bit_count), 32'h8888);
        chk("reload.pre_cfg", config_out, 32'h0);
        drive(1'b1, 4'b0000, 4'b0001, 1'b0);
        chk_all("reload", 32'h0000003C, 16'h9990, 4'b0001, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
